// File: rtl/ins_decoder_pipe.sv
// RV32I instruction field decoder: DEPTH-entry instruction FIFO feeding one registered decode stage.
// Optional `INSDEC_ILLEGAL_CHECK_EN adds a registered 'illegal' flag alongside the decoded fields.
module ins_decoder_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            instruction,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [6:0]             opcode,
  output logic [6:0]             funct7,
  output logic [2:0]             funct3,
  output logic [4:0]             rd,
  output logic [4:0]             rs1,
  output logic [4:0]             rs2,
  output logic [XLEN-1:0]        imm,
  output logic [2:0]             fmt,
  output logic [$clog2(DEPTH):0] count
`ifdef INSDEC_ILLEGAL_CHECK_EN
  ,
  output logic                   illegal
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]     r_mem [DEPTH];
  logic [PW-1:0]   r_wrPtr;
  logic [PW-1:0]   r_rdPtr;
  logic [CW-1:0]   r_count;
  logic            r_outValid;
  logic [6:0]      r_opcode;
  logic [6:0]      r_funct7;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [XLEN-1:0] r_imm;
  logic [2:0]      r_fmt;

  logic            w_push;
  logic            w_load;
  logic [31:0]     w_head;
  logic [2:0]      w_fmt;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;

  assign in_ready  = (r_count < CW'(DEPTH));
  assign w_push    = in_valid && in_ready;
  // The head is popped exactly when the output register takes it.
  assign w_load    = (r_count != '0) && (!r_outValid || out_ready);
  assign w_head    = r_mem[r_rdPtr];

  assign out_valid = r_outValid;
  assign opcode    = r_opcode;
  assign funct7    = r_funct7;
  assign funct3    = r_funct3;
  assign rd        = r_rd;
  assign rs1       = r_rs1;
  assign rs2       = r_rs2;
  assign imm       = r_imm;
  assign fmt       = r_fmt;
  assign count     = r_count;

  always_comb begin
    w_fmt = 3'd7;
    case (w_head[6:0])
      7'b0110011:                                     w_fmt = 3'd0;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: w_fmt = 3'd1;
      7'b0100011:                                     w_fmt = 3'd2;
      7'b1100011:                                     w_fmt = 3'd3;
      7'b0110111, 7'b0010111:                         w_fmt = 3'd4;
      7'b1101111:                                     w_fmt = 3'd5;
      default:                                        w_fmt = 3'd7;
    endcase
  end

  // Every format places instr[31] at bit 31, so one sign extension covers all of them.
  always_comb begin
    w_imm32 = '0;
    case (w_fmt)
      3'd1:    w_imm32 = {{20{w_head[31]}}, w_head[31:20]};
      3'd2:    w_imm32 = {{20{w_head[31]}}, w_head[31:25], w_head[11:7]};
      3'd3:    w_imm32 = {{19{w_head[31]}}, w_head[31], w_head[7], w_head[30:25], w_head[11:8], 1'b0};
      3'd4:    w_imm32 = {w_head[31:12], 12'b0};
      3'd5:    w_imm32 = {{11{w_head[31]}}, w_head[31], w_head[19:12], w_head[20], w_head[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
    w_imm = XLEN'($signed(w_imm32));
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= instruction;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_load) r_rdPtr <= r_rdPtr + PW'(1);
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outValid <= 1'b0;
      r_opcode   <= '0;
      r_funct7   <= '0;
      r_funct3   <= '0;
      r_rd       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_imm      <= '0;
      r_fmt      <= '0;
    end else if (w_load) begin
      r_outValid <= 1'b1;
      r_opcode   <= w_head[6:0];
      r_funct7   <= w_head[31:25];
      r_funct3   <= w_head[14:12];
      r_rd       <= w_head[11:7];
      r_rs1      <= w_head[19:15];
      r_rs2      <= w_head[24:20];
      r_imm      <= w_imm;
      r_fmt      <= w_fmt;
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

`ifdef INSDEC_ILLEGAL_CHECK_EN
  logic r_illegal;
  assign illegal = r_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_illegal <= 1'b0;
    else if (w_load) r_illegal <= (w_fmt == 3'd7) || (w_head[1:0] != 2'b11);
  end
`endif

endmodule
